// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: load/store sequencer for the data-memory stage.
// It captures one pipeline access and drives a req/ack word memory with byte
// enables and lane-replicated store data. It stalls the pipeline until the
// access completes, and it returns sign- or zero-extended load data.
// Optional feature macro: DM_MISALIGN_TRAP_EN. When it is defined, a misaligned
// access is answered with an error and no memory request. When it is not
// defined, a misaligned address is force-aligned.
module dm_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    // The counter only has to reach TIMEOUT_CYCLES-1, because the abort is
    // taken during the WAIT cycle in which it holds that value.
    localparam int unsigned   TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned   TLIM   = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [TW-1:0] TLIM_W = TW'(TLIM);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [3:0]          r_be;
    logic [31:0]         r_wdata;
    logic [1:0]          r_size;
    logic [1:0]          r_lane;
    logic                r_unsigned;
    logic [31:0]         r_rdata;
    logic                r_err;
    logic [TW-1:0]       r_tcnt;

    logic [3:0]          w_be;
    logic [31:0]         w_wdata;
    logic [7:0]          w_lb;
    logic [15:0]         w_lh;
    logic [31:0]         w_ext;
    logic                w_tmo;
    logic                w_trap;

`ifdef DM_MISALIGN_TRAP_EN
    logic                w_misalign;
    assign w_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
    assign w_trap     = w_misalign;
`else
    // Force-alignment needs no extra logic. Half enables use only addr[1], word
    // enables are all ones, and mem_addr always clears bits [1:0].
    assign w_trap     = 1'b0;
`endif

    assign w_tmo      = (TIMEOUT_CYCLES != 0) && (r_tcnt == TLIM_W);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    // Decode byte enables and replicated store data from the incoming request
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = req_wdata;
        case (req_size)
            2'b00: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = req_wdata;
            end
        endcase
    end

    // Select the load lane from the returned word and extend it to 32 bits
    always_comb begin
        w_lb  = mem_rdata[{r_lane, 3'b000} +: 8];
        w_lh  = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        w_ext = mem_rdata;
        case (r_size)
            2'b00:   w_ext = {{24{w_lb[7] & ~r_unsigned}}, w_lb};
            2'b01:   w_ext = {{16{w_lh[15] & ~r_unsigned}}, w_lh};
            default: w_ext = mem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        w_next     = r_state;
        stall      = 1'b0;
        mem_req    = 1'b0;
        resp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Gated by rst so that every output reads 0 while reset is held
                stall = req_valid & ~rst;
                if (req_valid) begin
                    w_next = w_trap ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ack || w_tmo) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                resp_valid = 1'b1;
                w_next     = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        mem_we    = mem_req & r_we;
        mem_addr  = mem_req ? r_addr  : '0;
        mem_be    = mem_req ? r_be    : '0;
        mem_wdata = mem_req ? r_wdata : '0;
    end

    // Capture the request, run the timeout counter and register the response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_size     <= '0;
            r_lane     <= '0;
            r_unsigned <= 1'b0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_tcnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_addr     <= {req_addr[ADDR_W-1:2], 2'b00};
                        r_be       <= w_be;
                        r_wdata    <= w_wdata;
                        r_size     <= req_size;
                        r_lane     <= req_addr[1:0];
                        r_unsigned <= req_unsigned;
                        r_tcnt     <= '0;
                        r_rdata    <= '0;
                        r_err      <= w_trap;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        r_rdata <= r_we ? '0 : w_ext;
                        r_err   <= 1'b0;
                    end else if (w_tmo) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end
                    if (r_tcnt != TLIM_W) begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                S_DONE: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl. It uses randomized and directed
// accesses, and it checks them against a byte-level reference model.
module tb_dm_access_ctrl;

    localparam int TO = 4;
`ifdef DM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    // observations of the last access
    int          o_reqc, o_lat, o_stallc;
    logic [31:0] o_addr, o_wd, o_rd;
    logic [3:0]  o_be;
    logic        o_we, o_err, o_stable, o_stall0;
    time         t_acc;

    always #5 clk = ~clk;

    dm_access_ctrl #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .stall(stall), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // ---------------- reference model (byte arithmetic) ----------------
    function automatic int unsigned m_n(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit m_mis(input logic [31:0] a, input logic [1:0] sz);
        return (a % m_n(sz)) != 0;
    endfunction

    function automatic int unsigned m_off(input logic [31:0] a, input logic [1:0] sz);
        return ((a % 4) / m_n(sz)) * m_n(sz);
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] sz);
        int unsigned v;
        v = ((1 << m_n(sz)) - 1) << m_off(a, sz);
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_wd(input logic [31:0] w, input logic [1:0] sz);
        if (m_n(sz) == 1) return (w % 256) * 32'h0101_0101;
        if (m_n(sz) == 2) return (w % 65536) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_rd(input logic [31:0] word, input logic [31:0] a,
                                         input logic [1:0] sz, input logic uns);
        longint v, span;
        span = longint'(1) << (8 * m_n(sz));
        v = (longint'(word) >> (8 * m_off(a, sz))) % span;
        if (!uns && m_n(sz) < 4 && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    // ---------------- access driver / memory responder ----------------
    // ack_at: WAIT cycle (1-based) in which mem_ack is returned; 0 = never
    task automatic run_access(input logic we, input logic [31:0] a, input logic [1:0] sz,
                              input logic uns, input logic [31:0] wd,
                              input logic [31:0] mword, input int ack_at);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz;
        req_unsigned = uns; req_wdata = wd;
        #1 o_stall0 = stall;
        @(posedge clk);
        t_acc = $time;
        #1 req_valid = 1'b0;
        req_wdata = $urandom;
        o_reqc = 0; o_lat = 0; o_stallc = 0; o_stable = 1'b1;
        o_addr = '0; o_wd = '0; o_rd = '0; o_be = '0; o_we = 1'b0; o_err = 1'b0;
        for (int k = 1; k <= 20 && o_lat == 0; k++) begin
            @(negedge clk);
            if (stall) o_stallc++;
            if (resp_valid) begin
                o_lat = k; o_rd = resp_rdata; o_err = resp_err;
            end
            if (mem_req) begin
                o_reqc++;
                if (o_reqc == 1) begin
                    o_addr = mem_addr; o_be = mem_be; o_we = mem_we; o_wd = mem_wdata;
                end else if (mem_addr !== o_addr || mem_be !== o_be ||
                             mem_we !== o_we || mem_wdata !== o_wd) begin
                    o_stable = 1'b0;
                end
            end
            mem_ack   = (ack_at != 0) && (k == ack_at);
            mem_rdata = mem_ack ? mword : $urandom;
        end
        mem_ack = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
        req_size = 2'd2; req_unsigned = 1'b0; req_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        #1;
        total++;
        if ({stall, resp_valid, resp_err, mem_req, mem_we, mem_be} !== 9'd0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0",
                     {stall, resp_valid, resp_err, mem_req, mem_we, mem_be});
        end
        total++;
        if ({resp_rdata, mem_addr, mem_wdata} !== 96'd0) begin
            bad++;
            $display("FAIL reset_data: got %h %h %h want 0", resp_rdata, mem_addr, mem_wdata);
        end
        repeat (2) @(posedge clk);
        total++;
        if (mem_req !== 1'b0) begin
            bad++; $display("FAIL reset_hold_req: got %b want 0", mem_req);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_directed();
        // signed byte load from the top lane
        run_access(1'b0, 32'h1003, 2'd0, 1'b0, 32'h0, 32'h8011_2233, 1);
        total++; if (o_stall0 !== 1'b1) begin bad++; $display("FAIL lb_stall_idle: got %b want 1", o_stall0); end
        total++; if (o_be !== 4'b1000) begin bad++; $display("FAIL lb_be: got %b want 1000", o_be); end
        total++; if (o_addr !== 32'h1000) begin bad++; $display("FAIL lb_addr: got %h want 1000", o_addr); end
        total++; if (o_rd !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_rdata: got %h want ffffff80", o_rd); end
        total++; if (o_lat !== 2) begin bad++; $display("FAIL lb_latency: got %0d want 2", o_lat); end
        // unsigned half load with ack after three wait cycles
        run_access(1'b0, 32'h2002, 2'd1, 1'b1, 32'h0, 32'hBEEF_1234, 4);
        total++; if (o_be !== 4'b1100) begin bad++; $display("FAIL lh_be: got %b want 1100", o_be); end
        total++; if (o_rd !== 32'h0000_BEEF) begin bad++; $display("FAIL lh_rdata: got %h want 0000beef", o_rd); end
        total++; if (o_stallc !== 4) begin bad++; $display("FAIL lh_stall_cycles: got %0d want 4", o_stallc); end
        total++; if (o_lat !== 5) begin bad++; $display("FAIL lh_latency: got %0d want 5", o_lat); end
        // byte store
        run_access(1'b1, 32'h0001, 2'd0, 1'b0, 32'h0000_00A5, 32'h1234_5678, 1);
        total++; if (o_we !== 1'b1) begin bad++; $display("FAIL sb_we: got %b want 1", o_we); end
        total++; if (o_be !== 4'b0010) begin bad++; $display("FAIL sb_be: got %b want 0010", o_be); end
        total++; if (o_wd !== 32'hA5A5_A5A5) begin bad++; $display("FAIL sb_wdata: got %h want a5a5a5a5", o_wd); end
        total++; if (o_rd !== 32'h0) begin bad++; $display("FAIL sb_rdata: got %h want 0", o_rd); end
        // misaligned word load
        run_access(1'b0, 32'h0006, 2'd2, 1'b0, 32'h0, 32'hCAFE_F00D, 1);
        if (TRAP) begin
            total++; if (o_reqc !== 0) begin bad++; $display("FAIL mis_no_req: got %0d want 0", o_reqc); end
            total++; if (o_lat !== 1 || o_err !== 1'b1 || o_rd !== 32'h0) begin
                bad++; $display("FAIL mis_trap: got lat=%0d err=%b rd=%h want 1 1 0", o_lat, o_err, o_rd);
            end
        end else begin
            total++; if (o_addr !== 32'h4 || o_be !== 4'b1111) begin
                bad++; $display("FAIL mis_align: got %h %b want 4 1111", o_addr, o_be);
            end
            total++; if (o_rd !== 32'hCAFE_F00D || o_err !== 1'b0) begin
                bad++; $display("FAIL mis_rdata: got %h err=%b want cafef00d 0", o_rd, o_err);
            end
        end
    endtask

    task automatic test_timeout();
        run_access(1'b0, 32'h3000, 2'd2, 1'b0, 32'h0, 32'h1111_2222, 0);
        total++; if (o_reqc !== TO) begin bad++; $display("FAIL to_req_cycles: got %0d want %0d", o_reqc, TO); end
        total++; if (o_lat !== TO + 1 || o_err !== 1'b1 || o_rd !== 32'h0) begin
            bad++; $display("FAIL to_abort: got lat=%0d err=%b rd=%h want %0d 1 0", o_lat, o_err, o_rd, TO + 1);
        end
        run_access(1'b0, 32'h3000, 2'd2, 1'b0, 32'h0, 32'h1111_2222, TO);
        total++; if (o_lat !== TO + 1 || o_err !== 1'b0 || o_rd !== 32'h1111_2222) begin
            bad++; $display("FAIL to_ack_wins: got lat=%0d err=%b rd=%h want %0d 0 11112222", o_lat, o_err, o_rd, TO + 1);
        end
    endtask

    task automatic test_rst_mid();
        int seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; req_size = 2'd2; req_unsigned = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if ({mem_req, stall, resp_valid} !== 3'b000) begin
            bad++; $display("FAIL rst_mid_drop: got %b want 000", {mem_req, stall, resp_valid});
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp_valid || mem_req) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rst_mid_quiet: got %0d want 0", seen); end
        run_access(1'b0, 32'h41, 2'd0, 1'b1, 32'h0, 32'h00C3_9A00, 2);
        total++; if (o_rd !== 32'h0000_009A || o_lat !== 3) begin
            bad++; $display("FAIL rst_mid_after: got rd=%h lat=%0d want 0000009a 3", o_rd, o_lat);
        end
    endtask

    task automatic test_back_to_back();
        time t0;
        run_access(1'b1, 32'h100, 2'd2, 1'b0, 32'h1, 32'h0, 1);
        t0 = t_acc;
        run_access(1'b0, 32'h104, 2'd1, 1'b0, 32'h0, 32'h0000_8001, 1);
        total++; if (t_acc - t0 !== 30) begin
            bad++; $display("FAIL b2b_spacing: got %0t want 30", t_acc - t0);
        end
        total++; if (o_rd !== 32'hFFFF_8001) begin bad++; $display("FAIL b2b_rdata: got %h want ffff8001", o_rd); end
    endtask

    task automatic test_random();
        logic        we, uns, mis;
        logic [31:0] a, wd, mw;
        logic [1:0]  sz;
        int          ack;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom); uns = 1'($urandom); sz = 2'($urandom);
            a = $urandom; wd = $urandom; mw = $urandom; ack = $urandom_range(1, 3);
            mis = TRAP && m_mis(a, sz);
            run_access(we, a, sz, uns, wd, mw, ack);
            if (mis) begin
                total++; if (o_reqc !== 0 || o_lat !== 1 || o_err !== 1'b1 || o_rd !== 32'h0) begin
                    bad++; $display("FAIL rnd_trap[%0d]: got req=%0d lat=%0d err=%b rd=%h want 0 1 1 0", i, o_reqc, o_lat, o_err, o_rd);
                end
            end else begin
                total++; if (o_addr !== (a & 32'hFFFF_FFFC) || o_be !== m_be(a, sz) || o_we !== we) begin
                    bad++; $display("FAIL rnd_req[%0d]: got %h %b %b want %h %b %b", i, o_addr, o_be, o_we, a & 32'hFFFF_FFFC, m_be(a, sz), we);
                end
                total++; if (o_wd !== m_wd(wd, sz) || o_stable !== 1'b1) begin
                    bad++; $display("FAIL rnd_wdata[%0d]: got %h stable=%b want %h 1", i, o_wd, o_stable, m_wd(wd, sz));
                end
                total++; if (o_rd !== (we ? 32'h0 : m_rd(mw, a, sz, uns)) || o_err !== 1'b0 || o_lat !== ack + 1) begin
                    bad++; $display("FAIL rnd_resp[%0d]: got rd=%h err=%b lat=%0d want %h 0 %0d", i, o_rd, o_err, o_lat, we ? 32'h0 : m_rd(mw, a, sz, uns), ack + 1);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_rst_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Load/store sequencer for the data-memory (DM) stage of the pipeline.
- Accepts one access per request and drives a variable-latency word memory with a req/ack handshake, byte enables and lane-replicated write data.
- Stalls the pipeline until the access completes.
- On loads, picks the byte or halfword lane and sign- or zero-extends it to 32 bits before returning it to writeback.

Parameters:
- TIMEOUT_CYCLES, 255: WAIT-state cycles without mem_ack before the access is aborted with an error; 0 disables the timeout.
- ADDR_W, 32: width of the byte address.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  pipeline presents an access.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_wdata  in  32  store data, right-aligned.
- stall  out  1  holds the pipeline.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid; access failed.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  word-aligned address, bits [1:0] = 0.
- mem_be  out  4  byte enables, little-endian, bit i = byte lane i.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory accepted or completed the access; mem_rdata valid this cycle.
- mem_rdata  in  32  read word.

Behaviour:
- Reset values (asynchronous, applied immediately): state IDLE, all outputs 0, timeout counter 0, captured request registers 0.
- States and transitions:
  - IDLE: if req_valid, capture the request and go to WAIT. stall = req_valid (combinational).
  - WAIT: mem_req = 1, stall = 1, and mem_we/mem_addr/mem_be/mem_wdata are stable from the captured registers.
    - mem_ack = 1: go to DONE. For loads, register the extended data in resp_rdata.
    - Timeout counter reaches TIMEOUT_CYCLES: go to DONE with resp_err = 1.
    - mem_ack and timeout in the same cycle: ack wins, no error.
  - DONE: resp_valid = 1, stall = 0, mem_req = 0; go to IDLE. req_valid is ignored in DONE, so the next access is accepted in the following IDLE cycle.
- Latency: minimum 2 cycles from acceptance to resp_valid (ack in the first WAIT cycle), plus 1 per extra wait cycle. Back-to-back throughput is one access per 3 cycles.
- Byte enables:
  - byte: 1 << addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- Write data:
  - byte: wdata[7:0] replicated x4
  - half: wdata[15:0] replicated x2
  - word: wdata unchanged
- Load extraction:
  - byte: lane mem_rdata[8*addr[1:0] +: 8], extended per req_unsigned
  - half: lane mem_rdata[16*addr[1] +: 16], extended per req_unsigned
  - word: mem_rdata unchanged, req_unsigned ignored
- Misaligned addresses (half with addr[0] = 1, word with addr[1:0] != 0) are handled per the optional feature below.
- Timeout counter: clears on entry to WAIT and saturates; it is not used when TIMEOUT_CYCLES = 0.
- On a timeout abort, mem_req drops in DONE and the memory must tolerate the abandoned request.
- rst asserted mid-access (WAIT or DONE): immediate return to IDLE, mem_req and resp_valid drop asynchronously, and no response is produced.

Optional Feature:
- Macro: DM_MISALIGN_TRAP_EN.
- Defined: a misaligned request accepted in IDLE goes directly to DONE with no memory request, producing resp_valid = 1, resp_err = 1, resp_rdata = 0.
- Undefined: misaligned addresses are force-aligned (half clears bit 0, word clears bits [1:0]) and the access proceeds normally.

Test Plan:
- Load byte, addr 0x1003, signed, mem_rdata 0x80112233, ack in first WAIT cycle -> mem_be 4'b1000, mem_addr 0x1000, resp_rdata 0xFFFFFF80, resp_valid 2 cycles after acceptance.
- Load half, addr 0x2002, unsigned, mem_rdata 0xBEEF1234, ack after 3 wait cycles -> mem_be 4'b1100, resp_rdata 0x0000BEEF, stall high for 4 cycles then low in DONE.
- Store byte, addr 0x0001, wdata 0x000000A5 -> mem_we 1, mem_be 4'b0010, mem_wdata 0xA5A5A5A5, resp_rdata 0.
- TIMEOUT_CYCLES = 4, mem_ack held 0 -> mem_req high for 4 cycles then drops, resp_valid = 1 and resp_err = 1; separate run with ack on the timeout cycle -> resp_err = 0.
- Word load, addr 0x0006 -> with DM_MISALIGN_TRAP_EN: no mem_req, resp_err = 1 next cycle; without it: mem_addr 0x0004, mem_be 4'b1111.
- rst pulsed during WAIT -> mem_req and stall drop at once, no resp_valid; a following request completes normally.
